// File: rtl/decision_wait_n.sv
// N-channel clocked decision-wait: one fire request is matched to exactly one channel request, with
// 2-phase or 4-phase signalling, optional input synchronisers, sticky violation flag and completion counter.
module decision_wait_n #(
  parameter int N          = 2,
  parameter int FOUR_PHASE = 0,
  parameter int SYNC       = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire,
  input  logic [N-1:0]     a,
  output logic [N-1:0]     z,
  output logic             busy,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic         w_f;
  logic [N-1:0] w_s;

  generate
    if (SYNC == 2) begin : g_sync
      logic [1:0]   r_f_sync;
      logic [N-1:0] r_a_sync0;
      logic [N-1:0] r_a_sync1;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_f_sync  <= '0;
          r_a_sync0 <= '0;
          r_a_sync1 <= '0;
        end else begin
          r_f_sync  <= {r_f_sync[0], fire};
          r_a_sync0 <= a;
          r_a_sync1 <= r_a_sync0;
        end
      end
      assign w_f = r_f_sync[1];
      assign w_s = r_a_sync1;
    end else begin : g_nosync
      assign w_f = fire;
      assign w_s = a;
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_z, w_z_nxt;
  logic [N-1:0]     r_hold, w_hold_nxt;
  logic [N-1:0]     r_s_prev;
  logic             r_fph, w_fph_nxt;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_err_set;
  logic             w_inc;
  logic [N-1:0]     w_pend;
  logic [N-1:0]     w_win;
  logic             w_fpend;

  // 2-phase: a channel is pending while its request level differs from its ack level.
  assign w_pend  = (FOUR_PHASE != 0) ? w_s : (w_s ^ r_z);
  assign w_win   = w_pend & (~w_pend + {{(N-1){1'b0}}, 1'b1});
  assign w_fpend = w_f ^ r_fph;

  always_comb begin
    w_state_nxt = r_state;
    w_z_nxt     = r_z;
    w_hold_nxt  = r_hold;
    w_fph_nxt   = r_fph;
    w_err_set   = 1'b0;
    w_inc       = 1'b0;
    if (FOUR_PHASE == 0) begin
      if (w_fpend && (|w_pend)) begin
        w_z_nxt   = r_z ^ w_win;
        w_fph_nxt = ~r_fph;
        w_inc     = 1'b1;
        w_err_set = |(w_pend & ~w_win);
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_f && (|w_s)) begin
            w_z_nxt     = r_z | w_win;
            w_hold_nxt  = w_win;
            w_state_nxt = S_HOLD;
            w_inc       = 1'b1;
            w_err_set   = |(w_s & ~w_win);
          end
        end
        default: begin
          // Other channels rising while a decision is held are violations only.
          w_err_set = |(w_s & ~r_s_prev & ~r_hold);
          if (!w_f && !(|(w_s & r_hold))) begin
            w_z_nxt     = r_z & ~r_hold;
            w_hold_nxt  = '0;
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_z      <= '0;
      r_hold   <= '0;
      r_s_prev <= '0;
      r_fph    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_z      <= w_z_nxt;
      r_hold   <= w_hold_nxt;
      r_s_prev <= w_s;
      r_fph    <= w_fph_nxt;
      r_err    <= w_err_set | (r_err & ~err_clr);
      if (w_inc) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign z     = r_z;
  assign err   = r_err;
  assign count = r_cnt;
  assign busy  = ~rst & ((FOUR_PHASE != 0) ? ((r_state == S_HOLD) | w_f) : w_fpend);

endmodule

// File: tb/tb_decision_wait_n.sv
// Directed bench for decision_wait_n: three instances cover 2-phase N=2 (CNT_W=3), 2-phase N=4,
// and 4-phase N=4 with 2-flop synchronisers.
module tb_decision_wait_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance A: N=2, 2-phase, SYNC=0, CNT_W=3
  logic       a_fire = 1'b0, a_clr = 1'b0;
  logic [1:0] a_a = '0, a_z;
  logic       a_busy, a_err;
  logic [2:0] a_cnt;
  decision_wait_n #(.N(2), .FOUR_PHASE(0), .SYNC(0), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .fire(a_fire), .a(a_a), .z(a_z),
    .busy(a_busy), .err(a_err), .err_clr(a_clr), .count(a_cnt));

  // Instance B: N=4, 2-phase, SYNC=0
  logic       b_fire = 1'b0, b_clr = 1'b0;
  logic [3:0] b_a = '0, b_z;
  logic       b_busy, b_err;
  logic [7:0] b_cnt;
  decision_wait_n #(.N(4), .FOUR_PHASE(0), .SYNC(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .fire(b_fire), .a(b_a), .z(b_z),
    .busy(b_busy), .err(b_err), .err_clr(b_clr), .count(b_cnt));

  // Instance C: N=4, 4-phase, SYNC=2
  logic       c_fire = 1'b0, c_clr = 1'b0;
  logic [3:0] c_a = '0, c_z;
  logic       c_busy, c_err;
  logic [7:0] c_cnt;
  decision_wait_n #(.N(4), .FOUR_PHASE(1), .SYNC(2), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .fire(c_fire), .a(c_a), .z(c_z),
    .busy(c_busy), .err(c_err), .err_clr(c_clr), .count(c_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_cnt [9];
    exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    tick(); tick();
    check("rst_a_z", 32'(a_z), 32'h0);
    check("rst_a_busy", 32'(a_busy), 32'h0);
    check("rst_b_err", 32'(b_err), 32'h0);
    check("rst_c_cnt", 32'(c_cnt), 32'h0);
    rst = 1'b0;
    tick();

    // Test 1: fire first, channel 1 three cycles later
    a_fire = 1'b1;
    #1 check("t1_busy0", 32'(a_busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_busy_wait", 32'(a_busy), 32'h1);
      check("t1_z_wait", 32'(a_z), 32'h0);
    end
    a_a = 2'b10;
    tick();
    check("t1_z", 32'(a_z), 32'h2);
    check("t1_cnt", 32'(a_cnt), 32'h1);
    check("t1_busy_done", 32'(a_busy), 32'h0);
    check("t1_err", 32'(a_err), 32'h0);

    // Clean reset, then async reset while fire pending with z=01
    rst = 1'b1; a_fire = 1'b0; a_a = '0;
    tick();
    rst = 1'b0;
    tick();
    a_a = 2'b01; a_fire = 1'b1;
    tick();
    check("r_z01", 32'(a_z), 32'h1);
    a_fire = 1'b0;
    tick();
    check("r_busy_pend", 32'(a_busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("r_async_z", 32'(a_z), 32'h0);
    check("r_async_busy", 32'(a_busy), 32'h0);
    check("r_async_cnt", 32'(a_cnt), 32'h0);
    a_a = '0; a_fire = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_no_spurious_z", 32'(a_z), 32'h0);
    end
    check("r_busy_after", 32'(a_busy), 32'h0);

    // Count wrap with CNT_W=3, back-to-back decisions
    for (int i = 0; i < 9; i++) begin
      a_fire = ~a_fire;
      a_a[0] = ~a_a[0];
      tick();
      check("cnt_seq", 32'(a_cnt), 32'(exp_cnt[i]));
      check("cnt_z", 32'(a_z), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    check("cnt_err", 32'(a_err), 32'h0);

    // Test 2: two channels pending, lowest wins, error flagged
    b_a = 4'b1010;
    tick();
    check("t2_z_nofire", 32'(b_z), 32'h0);
    check("t2_busy_nofire", 32'(b_busy), 32'h0);
    b_fire = 1'b1;
    tick();
    check("t2_z1", 32'(b_z), 32'h2);
    check("t2_err", 32'(b_err), 32'h1);
    b_fire = 1'b0;
    tick();
    check("t2_z2", 32'(b_z), 32'ha);
    check("t2_cnt", 32'(b_cnt), 32'h2);

    // err_clr against a simultaneous violation, then alone
    b_a = 4'b1001; b_fire = 1'b1; b_clr = 1'b1;
    tick();
    check("clr_z", 32'(b_z), 32'hb);
    check("clr_err_set_wins", 32'(b_err), 32'h1);
    b_a = 4'b1001; b_fire = 1'b1;
    tick();
    check("clr_err_alone", 32'(b_err), 32'h0);
    b_clr = 1'b0;
    b_fire = 1'b0;
    tick();
    check("clr_z_after", 32'(b_z), 32'h9);
    check("clr_cnt_after", 32'(b_cnt), 32'h4);
    check("clr_err_after", 32'(b_err), 32'h0);

    // Test 3: 4-phase with synchronisers
    c_a = 4'b0100;
    tick(); tick();
    c_fire = 1'b1;
    tick();
    check("t3_z_e1", 32'(c_z), 32'h0);
    tick();
    check("t3_z_e2", 32'(c_z), 32'h0);
    tick();
    check("t3_z_e3", 32'(c_z), 32'h4);
    check("t3_cnt1", 32'(c_cnt), 32'h1);
    check("t3_busy_hold", 32'(c_busy), 32'h1);
    c_fire = 1'b0; c_a = 4'b0000;
    tick(); tick();
    check("t3_z_held", 32'(c_z), 32'h4);
    tick();
    check("t3_z_rtz", 32'(c_z), 32'h0);
    check("t3_busy_rtz", 32'(c_busy), 32'h0);
    check("t3_cnt_rtz", 32'(c_cnt), 32'h1);
    check("t3_err0", 32'(c_err), 32'h0);
    c_a = 4'b0100; c_fire = 1'b1;
    tick(); tick(); tick();
    check("t3_z_again", 32'(c_z), 32'h4);
    check("t3_cnt2", 32'(c_cnt), 32'h2);
    c_a = 4'b0101;
    tick(); tick();
    check("t3_err_pre", 32'(c_err), 32'h0);
    tick();
    check("t3_err_hold", 32'(c_err), 32'h1);
    check("t3_z_unaffected", 32'(c_z), 32'h4);
    c_a = '0; c_fire = 1'b0;
    tick(); tick(); tick();
    check("t3_z_final", 32'(c_z), 32'h0);
    check("t3_err_sticky", 32'(c_err), 32'h1);
    check("t3_cnt_final", 32'(c_cnt), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
